pool_fmap_collector: RTL and testbench

Consumer-side collector for the layer-2 pooled feature maps. It captures the CH parallel signed pool output streams, each with its own valid strobe, into a per-channel frame buffer. Once every channel has delivered a full DIM×DIM map, it replays the buffer as one serialized channel-major raster stream with a valid/ready handshake for the next convolution stage. It sits between the per-channel conv/max-pool lanes and the layer-3 input.

---
 rtl/pool_fmap_collector_if.sv | 28 ++
 rtl/pool_fmap_collector.sv | 123 ++++++++++++
 tb/tb_pool_fmap_collector.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pool_fmap_collector_if.sv
// Bundles the pooled-lane input streams and the serialized output handshake
// of the feature-map collector.
interface pool_fmap_collector_if #(
  parameter int PP = 8,
  parameter int CH = 16
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH*(PP+1)-1:0] pool_in;
  logic [CH-1:0]        pool_valid;
  logic                 out_ready;
  logic signed [PP:0]   out_pxl;
  logic [CHW-1:0]       out_ch;
  logic                 out_valid;
  logic                 out_last;
  logic                 frame_done;
  logic                 overflow;

  modport master (
    output pool_in, pool_valid, out_ready,
    input  out_pxl, out_ch, out_valid, out_last, frame_done, overflow
  );

  modport slave (
    input  pool_in, pool_valid, out_ready,
    output out_pxl, out_ch, out_valid, out_last, frame_done, overflow
  );
endinterface

// File: rtl/pool_fmap_collector.sv
// Captures CH parallel pooled map streams into register banks, then replays
// the whole frame as one channel-major raster stream under valid/ready.
module pool_fmap_collector #(
  parameter int PP  = 8,
  parameter int CH  = 16,
  parameter int DIM = 5
) (
  input logic                  clk,
  input logic                  reset,
  pool_fmap_collector_if.slave bus
);
  localparam int N   = DIM * DIM;
  localparam int CW  = $clog2(N + 1);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [CW-1:0]  FULL_CNT   = CW'(N);
  localparam logic [CW-1:0]  ALMOST_CNT = CW'(N - 1);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(N - 1);
  localparam logic [CHW-1:0] LAST_CH    = CHW'(CH - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic signed [PP:0] bank [CH][N];
  logic [CW-1:0]      wr_cnt [CH];
  logic [IW-1:0]      rd_idx;
  logic [CHW-1:0]     rd_ch;
  logic [CH-1:0]      full;
  logic [CH-1:0]      full_nxt;
  logic [CH-1:0]      accept;
  logic               at_last;
  logic               xfer;
  logic               frame_end;
  logic               ovf_hit;
  logic               frame_done_q;
  logic               overflow_q;

  // full_nxt predicts the post-edge fill level so DRAIN starts on the final write
  always_comb begin
    full     = '0;
    full_nxt = '0;
    accept   = '0;
    for (int k = 0; k < CH; k++) begin
      full[k]     = (wr_cnt[k] == FULL_CNT);
      accept[k]   = (state == FILL) && bus.pool_valid[k] && !full[k];
      full_nxt[k] = full[k] || (accept[k] && (wr_cnt[k] == ALMOST_CNT));
    end
  end

  assign at_last = (rd_ch == LAST_CH) && (rd_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    frame_end = 1'b0;
    ovf_hit   = 1'b0;
    case (state)
      FILL: begin
        ovf_hit = |(bus.pool_valid & full);
        if (&full_nxt) state_nxt = DRAIN;
      end
      DRAIN: begin
        ovf_hit = |bus.pool_valid;
        xfer    = bus.out_ready;
        if (xfer && at_last) begin
          frame_end = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx       <= '0;
      rd_ch        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int k = 0; k < CH; k++) wr_cnt[k] <= '0;
    end else begin
      frame_done_q <= frame_end;
      if (ovf_hit) overflow_q <= 1'b1;
      if (frame_end) begin
        rd_idx <= '0;
        rd_ch  <= '0;
        for (int k = 0; k < CH; k++) wr_cnt[k] <= '0;
      end else begin
        if (xfer) begin
          if (rd_idx == LAST_IDX) begin
            rd_idx <= '0;
            rd_ch  <= rd_ch + CHW'(1);
          end else begin
            rd_idx <= rd_idx + IW'(1);
          end
        end
        for (int k = 0; k < CH; k++)
          if (accept[k]) wr_cnt[k] <= wr_cnt[k] + CW'(1);
      end
    end
  end

  // Sample storage needs no reset: outputs are forced to zero outside DRAIN
  always_ff @(posedge clk) begin
    for (int k = 0; k < CH; k++)
      if (!reset && accept[k])
        bank[k][wr_cnt[k]] <= bus.pool_in[k*(PP+1) +: (PP+1)];
  end

  assign bus.out_valid  = (state == DRAIN);
  assign bus.out_pxl    = bus.out_valid ? bank[rd_ch][rd_idx] : '0;
  assign bus.out_ch     = bus.out_valid ? rd_ch : '0;
  assign bus.out_last   = bus.out_valid && at_last;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_pool_fmap_collector.sv
// Scoreboard bench for pool_fmap_collector: expected raster frames are queued
// as stimulus is applied and retired by a negedge monitor.
module tb_pool_fmap_collector;
  localparam int PP  = 8;
  localparam int CH  = 16;
  localparam int DIM = 5;
  localparam int N   = DIM * DIM;

  typedef struct packed {
    logic [3:0] ch;
    logic [8:0] pxl;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   xfers = 0;
  bit   mon_en = 1'b0;
  bit   exp_done = 1'b0;
  bit   done_seen = 1'b0;
  bit   ready_mode = 1'b0;
  int   phase = 0;

  pool_fmap_collector_if #(.PP(PP), .CH(CH)) bus ();

  pool_fmap_collector #(.PP(PP), .CH(CH), .DIM(DIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] sample(int ch, int i);
    return 9'(8 * ch + i - 100);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetDut();
    mon_en = 1'b0;
    reset = 1'b1;
    bus.pool_valid = '1;
    bus.pool_in = '1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.pool_valid = '0;
    bus.pool_in = '0;
    q.delete();
    exp_done = 1'b0;
    done_seen = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_pxl", {23'd0, bus.out_pxl}, 0);
    checkOutput("rst_ch", bus.out_ch, 0);
    checkOutput("rst_last", bus.out_last, 0);
    checkOutput("rst_done", bus.frame_done, 0);
    checkOutput("rst_ovf", bus.overflow, 0);
    mon_en = 1'b1;
  endtask

  // channel k starts k*skew cycles late; extra_ch >= 0 gets a 26th sample
  task automatic applyStimulus(input int skew, input int extra_ch);
    int last_c;
    int i;
    last_c = (N - 1) + skew * (CH - 1);
    done_seen = 1'b0;
    xfers = 0;
    for (int ch = 0; ch < CH; ch++)
      for (int j = 0; j < N; j++)
        q.push_back('{ch: 4'(ch), pxl: sample(ch, j), last: (ch == CH - 1 && j == N - 1)});
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < CH; k++) begin
        i = c - k * skew;
        if (i >= 0 && i < N) begin
          bus.pool_valid[k] = 1'b1;
          bus.pool_in[k*9 +: 9] = sample(k, i);
        end else if (k == extra_ch && i == N) begin
          bus.pool_valid[k] = 1'b1;
          bus.pool_in[k*9 +: 9] = 9'h0AA;
        end else begin
          bus.pool_valid[k] = 1'b0;
          bus.pool_in[k*9 +: 9] = 9'h155;
        end
      end
      @(negedge clk);
      checkOutput("fill_idle", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    bus.pool_valid = '0;
    @(negedge clk);
    checkOutput("stream_start", bus.out_valid, 1);
  endtask

  task automatic waitFrame();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (done_seen) break;
    end
    checkOutput("frame_seen", done_seen, 1);
    checkOutput("q_empty", q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        bus.out_ready = (phase == 0 || phase == 3);
        phase = (phase + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
        phase = 0;
      end
    end
  end

  // Monitor: compare the offered sample against the queue head, retire on transfer
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("frame_done", bus.frame_done, exp_done);
      if (bus.frame_done) done_seen = 1'b1;
      exp_done = 1'b0;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checkOutput("spurious_valid", bus.out_valid, 0);
        end else begin
          checkOutput("pxl", {23'd0, bus.out_pxl}, {23'd0, q[0].pxl});
          checkOutput("ch", bus.out_ch, q[0].ch);
          checkOutput("last", bus.out_last, q[0].last);
          if (bus.out_ready) begin
            exp_done = q[0].last;
            void'(q.pop_front());
            xfers++;
          end
        end
      end else begin
        checkOutput("idle_zero", {bus.out_pxl, bus.out_ch, bus.out_last}, 0);
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    resetDut();

    applyStimulus(0, -1);
    checkOutput("ovf_clean", bus.overflow, 0);
    waitFrame();

    applyStimulus(1, -1);
    waitFrame();

    ready_mode = 1'b1;
    applyStimulus(0, -1);
    waitFrame();
    checkOutput("bp_xfers", xfers, 400);
    ready_mode = 1'b0;

    applyStimulus(1, 3);
    checkOutput("ovf_fill", bus.overflow, 1);
    waitFrame();

    resetDut();
    applyStimulus(0, -1);
    @(posedge clk);
    #1;
    bus.pool_valid[0] = 1'b1;
    bus.pool_in[8:0] = 9'h063;
    @(posedge clk);
    #1;
    bus.pool_valid = '0;
    @(negedge clk);
    checkOutput("ovf_drain", bus.overflow, 1);
    waitFrame();
    applyStimulus(0, -1);
    waitFrame();
    checkOutput("ovf_sticky", bus.overflow, 1);

    resetDut();
    applyStimulus(0, -1);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      if (xfers >= 137) break;
    end
    checkOutput("mid_xfers", xfers, 137);
    #1;
    resetDut();
    applyStimulus(0, -1);
    waitFrame();
    checkOutput("post_rst_xfers", xfers, 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
